// File: rtl/udc_pkg.sv
// Shared definitions for the modulus up/down counter: direction and mode
// encodings plus the per-cycle event record.
package udc_pkg;

  localparam logic UDC_UP   = 1'b1;
  localparam logic UDC_DOWN = 1'b0;
  localparam logic UDC_WRAP = 1'b0;
  localparam logic UDC_SAT  = 1'b1;

  // Boundary events produced by one step attempt.
  typedef struct packed {
    logic ovf;  // up step attempted at or above max_val
    logic unf;  // down step attempted at zero
  } udc_evt_t;

endpackage

// File: rtl/udc_next_state.sv
// Combinational next-count and event logic for the modulus up/down counter.
// Priority is clr > load > en; with none asserted the count holds.
module udc_next_state
  import udc_pkg::*;
#(
  parameter int          N       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic [N-1:0] count,
  input  logic [N-1:0] max_val,
  input  logic         up_down,
  input  logic         sat_mode,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         clr,
  output logic [N-1:0] next_count,
  output udc_evt_t     evt
);

  localparam logic [N-1:0] RST_COUNT = N'(RST_VAL);
  localparam logic [N-1:0] ONE       = N'(1);

  // Select the next count and flag any attempted step past a bound.
  always_comb begin
    next_count = count;
    evt        = '0;
    if (clr) begin
      next_count = RST_COUNT;
    end else if (load) begin
      // A loaded value never lands outside the current range.
      next_count = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (up_down == UDC_UP) begin
        if (count < max_val) begin
          next_count = count + ONE;
        end else begin
          evt.ovf    = 1'b1;
          next_count = (sat_mode == UDC_SAT) ? max_val : '0;
        end
      end else begin
        if (count == '0) begin
          evt.unf    = 1'b1;
          next_count = (sat_mode == UDC_SAT) ? '0 : max_val;
        end else if (count > max_val) begin
          // max_val was lowered under us: pull back into range silently.
          next_count = max_val;
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Up/down counter over the runtime range 0..max_val with wrap or saturate
// behaviour, terminal-count output and overflow/underflow reporting.
module mod_updown_counter
  import udc_pkg::*;
#(
  parameter int          N       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_down,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max_val,
  input  logic         sat_mode,
  input  logic         flag_clr,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf_p,
  output logic         unf_p,
  output logic         ovf_sticky,
  output logic         unf_sticky
);

  localparam logic [N-1:0] RST_COUNT = N'(RST_VAL);

  logic [N-1:0] count_q, count_d;
  logic         ovf_p_q, ovf_p_d;
  logic         unf_p_q, unf_p_d;
  logic         ovf_sticky_q, ovf_sticky_d;
  logic         unf_sticky_q, unf_sticky_d;
  udc_evt_t     evt;

  udc_next_state #(
    .N       (N),
    .RST_VAL (RST_VAL)
  ) u_next_state (
    .count      (count_q),
    .max_val    (max_val),
    .up_down    (up_down),
    .sat_mode   (sat_mode),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .clr        (clr),
    .next_count (count_d),
    .evt        (evt)
  );

  // Event pulses last one cycle; sticky flags set on an event, which beats flag_clr.
  always_comb begin
    ovf_p_d      = evt.ovf;
    unf_p_d      = evt.unf;
    ovf_sticky_d = evt.ovf | (ovf_sticky_q & ~flag_clr);
    unf_sticky_d = evt.unf | (unf_sticky_q & ~flag_clr);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= RST_COUNT;
      ovf_p_q      <= 1'b0;
      unf_p_q      <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_p_q      <= ovf_p_d;
      unf_p_q      <= unf_p_d;
      ovf_sticky_q <= ovf_sticky_d;
      unf_sticky_q <= unf_sticky_d;
    end
  end

  // Terminal count follows the registered count and live direction/bound.
  always_comb begin
    tc = ((up_down == UDC_UP) && (count_q >= max_val)) ||
         ((up_down == UDC_DOWN) && (count_q == '0));
  end

  assign count      = count_q;
  assign ovf_p      = ovf_p_q;
  assign unf_p      = unf_p_q;
  assign ovf_sticky = ovf_sticky_q;
  assign unf_sticky = unf_sticky_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Table-driven bench for mod_updown_counter (N=4, RST_VAL=0) with an
// expected-result queue popped after each clock edge.
module tb_mod_updown_counter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up_down = 1'b1, clr = 1'b0, load = 1'b0;
  logic [N-1:0] load_val = '0, max_val = 4'd9;
  logic         sat_mode = 1'b0, flag_clr = 1'b0;
  logic [N-1:0] count;
  logic         tc, ovf_p, unf_p, ovf_sticky, unf_sticky;

  mod_updown_counter #(.N(N), .RST_VAL(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .up_down    (up_down),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .max_val    (max_val),
    .sat_mode   (sat_mode),
    .flag_clr   (flag_clr),
    .count      (count),
    .tc         (tc),
    .ovf_p      (ovf_p),
    .unf_p      (unf_p),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, load, en, up, sat, fclr;
    logic [3:0] lv, mx;
    logic [3:0] cnt;
    logic       ovf, unf, os, us;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       ovf, unf, os, us, tc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(logic c, logic l, logic e, logic u, logic s, logic f,
                              int lv, int mx, int cnt, logic o, logic un,
                              logic os, logic us);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.up = u; v.sat = s; v.fclr = f;
    v.lv = 4'(lv); v.mx = 4'(mx); v.cnt = 4'(cnt);
    v.ovf = o; v.unf = un; v.os = os; v.us = us;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected tc from the currently driven direction and bound.
  task automatic push_exp(string tag, logic [3:0] cnt, logic o, logic un, logic os, logic us);
    exp_t x;
    x.tag = tag; x.cnt = cnt; x.ovf = o; x.unf = un; x.os = os; x.us = us;
    x.tc  = (up_down && (cnt >= max_val)) || (!up_down && (cnt == 4'd0));
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    x = sb.pop_front();
    chk({x.tag, ".count"}, int'(count), int'(x.cnt));
    chk({x.tag, ".ovf_p"}, int'(ovf_p), int'(x.ovf));
    chk({x.tag, ".unf_p"}, int'(unf_p), int'(x.unf));
    chk({x.tag, ".ovf_sticky"}, int'(ovf_sticky), int'(x.os));
    chk({x.tag, ".unf_sticky"}, int'(unf_sticky), int'(x.us));
    chk({x.tag, ".tc"}, int'(tc), int'(x.tc));
    $display("[TB] %s count=%0d ovf_p=%0d unf_p=%0d os=%0d us=%0d tc=%0d",
             x.tag, count, ovf_p, unf_p, ovf_sticky, unf_sticky, tc);
  endtask

  task automatic drive(vec_t v);
    clr = v.clr; load = v.load; en = v.en; up_down = v.up; sat_mode = v.sat;
    flag_clr = v.fclr; load_val = v.lv; max_val = v.mx;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario 1: count up, mod 10, wrap.
    for (int i = 1; i <= 12; i++) begin
      int c;
      c = (i <= 9) ? i : i - 10;
      vecs.push_back(mk(0,0,1,1,0,0, 0,9, c, (i == 10), 0, (i >= 10), 0));
    end
    // Scenario 2: load 2 (also clearing flags), then saturate down.
    vecs.push_back(mk(0,1,0,1,0,1, 2,9, 2, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0,9, 1, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0,9, 0, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,0,1,0, 0,9, 0, 0,1, 0,1));
    vecs.push_back(mk(0,0,1,0,1,0, 0,9, 0, 0,1, 0,1));
    // Scenario 3: priority, clamp on load, wrap on overflow.
    vecs.push_back(mk(1,1,1,1,0,0, 5,9, 0, 0,0, 0,1));
    vecs.push_back(mk(0,1,0,1,0,0, 15,9, 9, 0,0, 0,1));
    vecs.push_back(mk(0,0,1,1,0,0, 0,9, 0, 1,0, 1,1));
    // Scenario 4: runtime max_val drop.
    vecs.push_back(mk(0,1,0,1,0,0, 8,9, 8, 0,0, 1,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0,5, 5, 0,0, 1,1));
    vecs.push_back(mk(0,1,0,1,0,0, 8,9, 8, 0,0, 1,1));
    vecs.push_back(mk(0,0,1,1,1,0, 0,5, 5, 1,0, 1,1));
    // Scenario 5: sticky flags, set beats clear.
    vecs.push_back(mk(0,0,0,1,1,1, 0,5, 5, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,1,1,1, 0,5, 5, 1,0, 1,0));
    vecs.push_back(mk(0,0,0,1,1,1, 0,5, 5, 0,0, 0,0));
    // max_val = 0: every step is an event, count pinned at 0.
    vecs.push_back(mk(0,1,0,1,0,0, 3,0, 0, 0,0, 0,0));
    vecs.push_back(mk(0,0,1,1,0,0, 0,0, 0, 1,0, 1,0));
    vecs.push_back(mk(0,0,1,0,0,0, 0,0, 0, 0,1, 1,1));
    vecs.push_back(mk(0,0,1,0,1,0, 0,0, 0, 0,1, 1,1));
    // Hold, then wrap down from 0 to max_val.
    vecs.push_back(mk(0,0,0,1,0,0, 0,9, 0, 0,0, 1,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0,9, 9, 0,1, 1,1));
    vecs.push_back(mk(0,0,1,0,0,0, 0,9, 8, 0,0, 1,1));
    vecs.push_back(mk(0,1,0,1,0,0, 7,9, 7, 0,0, 1,1));

    // Reset state while rst is held.
    #12;
    push_exp("reset", 4'd0, 0, 0, 0, 0);
    pop_check();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      push_exp($sformatf("row%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf,
               vecs[i].os, vecs[i].us);
      @(posedge clk);
      #1;
      pop_check();
    end

    // Asynchronous reset between edges at count=7 with both stickies set.
    load = 1'b0; en = 1'b0; up_down = 1'b1; max_val = 4'd9;
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", 4'd0, 0, 0, 0, 0);
    pop_check();
    #1;
    rst = 1'b0;
    en  = 1'b1;
    push_exp("after_rst", 4'd1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    pop_check();
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
